// File: rtl/cpu_defs.sv
// cpu_defs: definitions shared by the ID stage, the ALU control decode and the
// execute stage.
//   - ALUOp encodings driven by the main decoder
//   - R-type funct codes for the ops the EX stage executes
//   - encoding of the iterative multiplier's FSM states
//   - decode_alu(): maps ALUOp/funct to a single ALU operation
package cpu_defs;

  // ALUOp from the main decoder
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRType = 2'b10;
  localparam logic [1:0] AluOpOr    = 2'b11;

  // R-type funct field (inst[5:0])
  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctAnd = 6'h24;
  localparam logic [5:0] FunctOr  = 6'h25;
  localparam logic [5:0] FunctMul = 6'h18;

  // Iterative multiplier FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mul_state_e;

  // Decoded ALU operation; AluNone forces a zero result
  typedef enum logic [2:0] {
    AluNone = 3'd0,
    AluAdd  = 3'd1,
    AluSub  = 3'd2,
    AluAnd  = 3'd3,
    AluOr   = 3'd4,
    AluMul  = 3'd5
  } alu_ctrl_e;

  function automatic alu_ctrl_e decode_alu(logic [1:0] alu_op, logic [5:0] funct);
    alu_ctrl_e ctrl;
    ctrl = AluNone;
    case (alu_op)
      AluOpAdd: ctrl = AluAdd;
      AluOpSub: ctrl = AluSub;
      AluOpOr:  ctrl = AluOr;
      default: begin
        case (funct)
          FunctAdd: ctrl = AluAdd;
          FunctSub: ctrl = AluSub;
          FunctAnd: ctrl = AluAnd;
          FunctOr:  ctrl = AluOr;
          FunctMul: ctrl = AluMul;
          default:  ctrl = AluNone;
        endcase
      end
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier, one partial-product step per clock.
// State updates on the falling edge of clk_i; reset is asynchronous, active-high.
// Ports:
//   clk_i    clock (negedge-active)
//   rst_i    asynchronous active-high reset, discards any product in flight
//   start    request; operands are captured on the IDLE->BUSY edge
//   a, b     multiplicand, multiplier
//   abort    drop the operation in progress (BUSY/DONE -> IDLE)
//   busy     FSM is not IDLE
//   done     FSM is in DONE; product is valid for this cycle
//   product  low WIDTH bits of a*b (identical for signed and unsigned)
module mul_iter
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  mul_state_e       r_state;
  logic [CntW-1:0]  r_count;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= StBusy;
          end
        end
        StBusy: begin
          if (abort) begin
            r_state <= StIdle;
          end else begin
            // Bits shifted past WIDTH are dropped, giving the product mod 2^WIDTH.
            if (r_mplier[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CntW'(1);
            // The step taken on this edge is the last one.
            if (r_count == LastCnt) begin
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy    = (r_state != StIdle);
  assign done    = (r_state == StDone);
  assign product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
// Single-cycle ALU (add/sub/and/or) plus an iterative multiplier for R-type MUL,
// destination register select and store-data pass-through.
// Ports:
//   clk_i, rst_i   clock (negedge-active state), asynchronous active-high reset
//   a_i, b_i       rs / rt operands
//   immediate_i    sign-extended immediate, used as operand B when ALUSrc_i = 1
//   ALUOp_i        00 add, 01 sub, 10 R-type (decode funct), 11 or
//   RegDst_i       1: dest = inst_i[15:11], 0: dest = inst_i[20:16]
//   inst_i         instruction word, funct = inst_i[5:0]
//   result_o       ALU or multiply result
//   zero_o         result_o == 0
//   wr_addr_o      destination register number
//   store_data_o   b_i, for stores
//   stall_o        hold PC, IF/ID and ID/EX while a multiply is in flight
//   busy_o         multiplier FSM is not IDLE
module ex_stage
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] immediate_i,
  input  logic             ALUSrc_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             RegDst_i,
  input  logic [31:0]      inst_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic [4:0]       wr_addr_o,
  output logic [WIDTH-1:0] store_data_o,
  output logic             stall_o,
  output logic             busy_o
);

  logic [5:0]       w_funct;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_alu_result;
  logic [WIDTH-1:0] w_product;
  alu_ctrl_e        w_alu_ctrl;
  logic             w_is_mul;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic             w_unused_inst;

  assign w_funct       = inst_i[5:0];
  assign w_op_b        = ALUSrc_i ? immediate_i : b_i;
  assign w_alu_ctrl    = decode_alu(ALUOp_i, w_funct);
  assign w_is_mul      = (ALUOp_i == AluOpRType) && (w_funct == FunctMul);
  // rs/opcode/shamt fields are consumed by other stages
  assign w_unused_inst = ^{inst_i[31:21], inst_i[10:6]};

  always_comb begin
    w_alu_result = '0;
    case (w_alu_ctrl)
      AluAdd:  w_alu_result = a_i + w_op_b;
      AluSub:  w_alu_result = a_i - w_op_b;
      AluAnd:  w_alu_result = a_i & w_op_b;
      AluOr:   w_alu_result = a_i | w_op_b;
      default: w_alu_result = '0;
    endcase
  end

  // A falling is_mul while BUSY/DONE means the instruction was flushed.
  mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul_iter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (w_is_mul),
    .a      (a_i),
    .b      (w_op_b),
    .abort  (!w_is_mul),
    .busy   (w_mul_busy),
    .done   (w_mul_done),
    .product(w_product)
  );

  // Hide partial products: a mul shows zero until its DONE cycle.
  assign result_o     = w_is_mul ? (w_mul_done ? w_product : '0) : w_alu_result;
  assign zero_o       = (result_o == '0);
  assign wr_addr_o    = RegDst_i ? inst_i[15:11] : inst_i[20:16];
  assign store_data_o = b_i;
  assign stall_o      = w_is_mul && !w_mul_done;
  assign busy_o       = w_mul_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, operand/dest muxes, multiplier timing,
// back-to-back multiplies, reset mid-multiply and flush.
module tb_ex_stage;

  localparam int unsigned WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] immediate_i;
  logic             ALUSrc_i;
  logic [1:0]       ALUOp_i;
  logic             RegDst_i;
  logic [31:0]      inst_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic [4:0]       wr_addr_o;
  logic [WIDTH-1:0] store_data_o;
  logic             stall_o;
  logic             busy_o;

  int checks = 0;
  int fails  = 0;

  ex_stage #(
    .WIDTH(WIDTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .immediate_i (immediate_i),
    .ALUSrc_i    (ALUSrc_i),
    .ALUOp_i     (ALUOp_i),
    .RegDst_i    (RegDst_i),
    .inst_i      (inst_i),
    .result_o    (result_o),
    .zero_o      (zero_o),
    .wr_addr_o   (wr_addr_o),
    .store_data_o(store_data_o),
    .stall_o     (stall_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // DUT state moves on negedge; step past it and let outputs settle.
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] funct);
    return {6'd0, 5'd1, rt, rd, 5'd0, funct};
  endfunction

  task automatic set_r(input logic [31:0] a, input logic [31:0] b, input logic [5:0] funct);
    a_i      = a;
    b_i      = b;
    ALUSrc_i = 1'b0;
    ALUOp_i  = 2'b10;
    RegDst_i = 1'b1;
    inst_i   = mk_r(5'd3, 5'd10, funct);
    #1;
  endtask

  // Issue a mul from IDLE and hold it until DONE; expects 33 stall cycles.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int n;
    set_r(a, b, 6'h18);
    n = 0;
    while (stall_o === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'd33);
    check({tag, "_result"}, result_o, exp);
    check({tag, "_stall_done"}, 32'(stall_o), 32'd0);
    check({tag, "_busy_done"}, 32'(busy_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    a_i         = '0;
    b_i         = '0;
    immediate_i = '0;
    ALUSrc_i    = 1'b0;
    ALUOp_i     = 2'b00;
    RegDst_i    = 1'b0;
    inst_i      = '0;
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_zero", 32'(zero_o), 32'd1);
    rst_i = 1'b0;
    tick();

    // R-type ALU ops
    set_r(32'd5, 32'd7, 6'h20);
    check("add_result", result_o, 32'd12);
    check("add_zero", 32'(zero_o), 32'd0);
    check("add_stall", 32'(stall_o), 32'd0);
    check("add_wr_rd", 32'(wr_addr_o), 32'd10);
    check("add_store", store_data_o, 32'd7);
    RegDst_i = 1'b0;
    #1;
    check("add_wr_rt", 32'(wr_addr_o), 32'd3);
    set_r(32'd0, 32'd1, 6'h22);
    check("sub_wrap", result_o, 32'hFFFF_FFFF);
    set_r(32'h0000_F0F0, 32'h0000_FF00, 6'h24);
    check("and_result", result_o, 32'h0000_F000);
    set_r(32'h0000_F0F0, 32'h0000_FF00, 6'h25);
    check("or_funct", result_o, 32'h0000_FFF0);
    set_r(32'd5, 32'd7, 6'h2A);
    check("bad_funct", result_o, 32'd0);
    check("bad_funct_zero", 32'(zero_o), 32'd1);

    // beq-style subtract, ALUOp or, addi with immediate
    ALUOp_i = 2'b01;
    a_i     = 32'h1234;
    b_i     = 32'h1234;
    #1;
    check("beq_result", result_o, 32'd0);
    check("beq_zero", 32'(zero_o), 32'd1);
    ALUOp_i = 2'b11;
    a_i     = 32'h00A0;
    b_i     = 32'h000B;
    #1;
    check("aluop_or", result_o, 32'h00AB);
    ALUOp_i     = 2'b00;
    ALUSrc_i    = 1'b1;
    immediate_i = 32'hFFFF_FFFF;
    a_i         = 32'd1;
    b_i         = 32'h55;
    #1;
    check("addi_result", result_o, 32'd0);
    check("addi_zero", 32'(zero_o), 32'd1);
    check("addi_store", store_data_o, 32'h55);
    tick();

    // Multiply 6*7, then leave mul
    run_mul("mul6x7", 32'd6, 32'd7, 32'd42);
    check("mul6x7_zero", 32'(zero_o), 32'd0);
    ALUOp_i = 2'b00;
    #1;
    tick();
    check("mul6x7_idle_busy", 32'(busy_o), 32'd0);
    check("mul6x7_idle_add", result_o, 32'd13);

    // Wrap-around product, then back-to-back mul
    run_mul("mulwrap", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    set_r(32'd3, 32'd3, 6'h18);
    tick();
    check("b2b_idle_busy", 32'(busy_o), 32'd0);
    check("b2b_idle_stall", 32'(stall_o), 32'd1);
    check("b2b_idle_result", result_o, 32'd0);
    run_mul("mul3x3", 32'd3, 32'd3, 32'd9);
    set_r(32'd3, 32'd3, 6'h20);
    tick();

    // Reset in the middle of a multiply
    set_r(32'd9, 32'd9, 6'h18);
    repeat (10) tick();
    check("rst_mid_busy_pre", 32'(busy_o), 32'd1);
    check("rst_mid_partial", result_o, 32'd0);
    rst_i = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b0;
    #1;
    run_mul("mul2x5", 32'd2, 32'd5, 32'd10);
    set_r(32'd0, 32'd0, 6'h20);
    tick();

    // Flush: mul replaced by add mid-BUSY
    set_r(32'd4, 32'd4, 6'h18);
    repeat (5) tick();
    check("flush_busy_pre", 32'(busy_o), 32'd1);
    set_r(32'd1, 32'd1, 6'h20);
    check("flush_stall", 32'(stall_o), 32'd0);
    check("flush_result", result_o, 32'd2);
    tick();
    check("flush_busy_post", 32'(busy_o), 32'd0);
    check("flush_result_post", result_o, 32'd2);
    tick();
    check("flush_stays_idle", 32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
